pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Program-counter sequencer that consumes the divided slow clock (clk_out of the clock divider, 1 Hz class) as a step enable. Runs entirely in the fast system clock domain: rising edges of the slow clock are detected and turned into single-cycle advance strobes. Supports run, halt and single-step control, plus a valid/ready load port for jumps. Drives the 16-bit PC into the fetch path of the cpu-16 core and onto board display logic.

Parameters:
PC_WIDTH, 16, width of program counter.
RESET_ADDR, 16'h0000, PC value after reset.
PC_INC, 1, increment applied per advance strobe.
END_ADDR, 16'hFFFF, last legal address; used only when PC_BOUND_EN is defined.

Ports:
clk  input  1  system clock, same clock driving the divider.
reset  input  1  asynchronous, active-high reset.
tick_in  input  1  divided slow clock from divider; a register output in the clk domain, no synchronizer.
run  input  1  level; 1 = free-run on every tick edge.
step  input  1  pulse, one clk cycle; request exactly one advance at next tick edge.
halt  input  1  pulse; stop advancing, overrides run.
load_valid  input  1  jump request valid.
load_addr  input  PC_WIDTH  jump target.
load_ready  output  1  jump accepted this cycle when high together with load_valid.
pc_out  output  PC_WIDTH  current program counter.
pc_adv  output  1  one-cycle pulse, high the cycle after pc_out changes by advance or load.
state_out  output  2  current FSM state encoding.
wrapped  output  1  sticky; set when PC wraps, cleared by load or reset.

Behaviour:
- Reset (async, immediate): pc_out=RESET_ADDR, state=HALTED (2'b00), pc_adv=0, wrapped=0, load_ready=0, edge-detect history register=0.
- Edge detect: tick_rise = tick_in & ~tick_d; tick_d registered every clk. Exactly one strobe per slow-clock rising edge. Falling edges ignored.
- States: HALTED(00), RUNNING(01), STEP_ARMED(10), LOADING(11).
- HALTED: run=1 -> RUNNING; step -> STEP_ARMED; load_valid -> LOADING.
- RUNNING: each tick_rise advances PC. halt or run=0 -> HALTED; load_valid -> LOADING.
- STEP_ARMED: first tick_rise advances PC once, then -> HALTED. halt cancels -> HALTED, no advance. Further step pulses while armed ignored.
- LOADING: load_ready=1 for exactly one cycle; pc_out<=load_addr on the handshake cycle; next state RUNNING if run=1, else HALTED. load_ready=0 in every other state.
- Priority in same cycle: load_valid > halt > step > run > tick_rise. A tick_rise coinciding with load/halt is dropped, not deferred.
- Advance latency: pc_out updates on the clk edge after tick_rise (2 clk after tick_in rises); pc_adv high the following cycle.
- Arithmetic: pc_next = pc_out + PC_INC, truncated to PC_WIDTH; natural modulo wrap. Wrap (carry out) sets wrapped.
- load_addr taken verbatim; no alignment check.
- Reset mid-operation: any state/pending step abandoned; no pc_adv generated on reset release.

Optional Feature:
Macro PC_BOUND_EN. Defined: when pc_out==END_ADDR, advance yields RESET_ADDR and sets wrapped; load_addr > END_ADDR is still accepted and then wraps on next advance. Not defined: END_ADDR ignored; wrap only at 2^PC_WIDTH.

Decomposition:
- Package cpu16_pc_pkg: state encodings (HALTED/RUNNING/STEP_ARMED/LOADING), PC_WIDTH default, RESET_ADDR default.
- One sub-module: tick_edge_detect (clk, reset, tick_in -> tick_rise); reusable for other slow-clock consumers.

Test Plan:
- Reset asserted mid-RUNNING with pc=16'h0005 -> pc_out=16'h0000, state_out=00, wrapped=0 same cycle (async).
- run=1, drive 3 tick_in rising edges -> pc_out 0->1->2->3, exactly 3 pc_adv pulses, each 1 cycle, none on falling edges.
- step pulse then 2 tick edges -> pc advances once (0->1), state returns to 00, second edge ignored.
- In RUNNING, load_valid with load_addr=16'h00A0 on same cycle as tick_rise -> load_ready=1 one cycle, pc_out=16'h00A0, no extra increment, pc_adv pulses once.
- load 16'hFFFF, run, one tick -> pc_out=16'h0000, wrapped=1; with PC_BOUND_EN and END_ADDR=16'h00FF, load 16'h00FF + one tick -> pc_out=RESET_ADDR, wrapped=1.
- STEP_ARMED then halt pulse before tick -> state 00, pc unchanged across subsequent tick.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cpu16_pc_pkg
//
// Shared definitions for the cpu-16 program-counter sequencer: FSM state
// encodings (these values are visible on state_out, so they are fixed) and
// the default geometry used by the sequencer and its load interface.
// ---------------------------------------------------------------------------
package cpu16_pc_pkg;

    // Default program-counter width for the cpu-16 core.
    localparam int unsigned PC_WIDTH_DEF = 16;

    // PC value after reset.
    localparam logic [15:0] RESET_ADDR_DEF = 16'h0000;

    // Last legal address when address bounding is compiled in.
    localparam logic [15:0] END_ADDR_DEF = 16'hFFFF;

    // Sequencer states; the encoding is driven straight onto state_out.
    typedef enum logic [1:0] {
        ST_HALTED     = 2'b00,
        ST_RUNNING    = 2'b01,
        ST_STEP_ARMED = 2'b10,
        ST_LOADING    = 2'b11
    } pc_state_e;

endpackage : cpu16_pc_pkg

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//
// Jump/load port of the program-counter sequencer (valid/ready handshake).
//   load_valid : jump request valid            (master -> slave)
//   load_addr  : jump target, PC_WIDTH bits    (master -> slave)
//   load_ready : jump accepted this cycle when high together with load_valid
//                                              (slave -> master)
// Modports: master = requester of the jump, slave = the sequencer.
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int unsigned PC_WIDTH = cpu16_pc_pkg::PC_WIDTH_DEF
);

    logic                load_valid;
    logic [PC_WIDTH-1:0] load_addr;
    logic                load_ready;

    modport master (
        output load_valid,
        output load_addr,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_addr,
        output load_ready
    );

endinterface : pc_sequencer_if

// File: rtl/pc_sequencer_tick_edge_detect.sv
// ---------------------------------------------------------------------------
// tick_edge_detect
//
// Turns a slow clock that is already a register output in the clk domain
// into one single-cycle strobe per rising edge.  Falling edges produce
// nothing.  No synchronizer is needed because tick_in is generated in the
// same clock domain.  The strobe is registered, so it appears one clk after
// tick_in rises.
//
// Ports:
//   clk       : system clock
//   reset     : asynchronous, active-high reset
//   tick_in   : slow clock (divider output)
//   tick_rise : one-cycle strobe per rising edge of tick_in
// ---------------------------------------------------------------------------
module tick_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic tick_in,
    output logic tick_rise
);

    logic tick_d_r;
    logic tick_rise_r;

    // History register and registered rising-edge strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_d_r    <= 1'b0;
            tick_rise_r <= 1'b0;
        end else begin
            tick_d_r    <= tick_in;
            tick_rise_r <= tick_in & ~tick_d_r;
        end
    end

    assign tick_rise = tick_rise_r;

endmodule : tick_edge_detect

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for the cpu-16 core.  Uses the divided slow
// clock as a step enable: every rising edge of tick_in becomes a single
// advance strobe in the fast clk domain.  Supports free-run, halt,
// single-step and a valid/ready jump port.
//
// Ports:
//   clk       : system clock (same clock as the divider)
//   reset     : asynchronous, active-high reset
//   tick_in   : divided slow clock (register output in clk domain)
//   run       : level, 1 = advance on every slow-clock rising edge
//   step      : one-cycle pulse, arm exactly one advance on the next edge
//   halt      : one-cycle pulse, stop advancing (overrides run/step)
//   load_if   : jump port (slave modport: load_valid, load_addr, load_ready)
//   pc_out    : current program counter
//   pc_adv    : one-cycle pulse, high the cycle after pc_out changed by an
//               advance or a load
//   state_out : current FSM state (00 halted, 01 running, 10 step armed,
//               11 loading)
//   wrapped   : sticky, set when the PC wraps; cleared by a load or reset
//
// Compile-time option:
//   PC_BOUND_EN : when defined, an advance from pc_out >= END_ADDR yields
//                 RESET_ADDR and sets wrapped.  When undefined, END_ADDR is
//                 ignored and the PC wraps only at 2**PC_WIDTH.
//
// Same-cycle priority: load_valid > halt > step > run > slow-clock edge.
// A slow-clock edge that collides with a load or halt is dropped.
// ---------------------------------------------------------------------------
module pc_sequencer
    import cpu16_pc_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_ADDR = PC_WIDTH'(RESET_ADDR_DEF),
    parameter int unsigned         PC_INC     = 1,
    parameter logic [PC_WIDTH-1:0] END_ADDR   = PC_WIDTH'(END_ADDR_DEF)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_in,
    input  logic                run,
    input  logic                step,
    input  logic                halt,
    pc_sequencer_if.slave       load_if,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                pc_adv,
    output logic [1:0]          state_out,
    output logic                wrapped
);

    // Increment widened by one bit so the carry out of the PC is visible.
    localparam logic [PC_WIDTH:0] INC_EXT = (PC_WIDTH + 1)'(PC_INC);

`ifdef PC_BOUND_EN
    localparam logic BOUND_EN = 1'b1;
`else
    localparam logic BOUND_EN = 1'b0;
`endif

    pc_state_e           state_r;
    logic [PC_WIDTH-1:0] pc_r;
    logic                wrapped_r;
    logic                load_ready_r;
    logic                adv_pend_r;    // PC changed on the previous edge
    logic                pc_adv_r;

    logic                tick_rise_s;
    logic [PC_WIDTH:0]   sum_s;
    logic [PC_WIDTH-1:0] adv_pc_s;
    logic                adv_wrap_s;

    tick_edge_detect u_tick_edge_detect (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (tick_in),
        .tick_rise (tick_rise_s)
    );

    // Next PC for an advance, and whether that advance counts as a wrap.
    always_comb begin
        sum_s      = {1'b0, pc_r} + INC_EXT;
        adv_pc_s   = sum_s[PC_WIDTH-1:0];
        adv_wrap_s = sum_s[PC_WIDTH];
        // A PC loaded beyond the bound also wraps on its next advance.
        if (BOUND_EN && (pc_r >= END_ADDR)) begin
            adv_pc_s   = RESET_ADDR;
            adv_wrap_s = 1'b1;
        end else begin
            adv_pc_s   = sum_s[PC_WIDTH-1:0];
            adv_wrap_s = sum_s[PC_WIDTH];
        end
    end

    // Sequencer FSM with registered PC, handshake and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_HALTED;
            pc_r         <= RESET_ADDR;
            wrapped_r    <= 1'b0;
            load_ready_r <= 1'b0;
            adv_pend_r   <= 1'b0;
            pc_adv_r     <= 1'b0;
        end else begin
            // pc_adv trails the PC update by one cycle.
            pc_adv_r     <= adv_pend_r;
            adv_pend_r   <= 1'b0;
            load_ready_r <= 1'b0;

            case (state_r)
                ST_LOADING: begin
                    // load_ready is high during this single cycle only.
                    if (load_if.load_valid) begin
                        pc_r       <= load_if.load_addr;
                        wrapped_r  <= 1'b0;
                        adv_pend_r <= 1'b1;
                    end else begin
                        pc_r <= pc_r;
                    end
                    state_r <= run ? ST_RUNNING : ST_HALTED;
                end

                ST_HALTED: begin
                    if (load_if.load_valid) begin
                        state_r      <= ST_LOADING;
                        load_ready_r <= 1'b1;
                    end else if (halt) begin
                        state_r <= ST_HALTED;
                    end else if (step) begin
                        state_r <= ST_STEP_ARMED;
                    end else if (run) begin
                        state_r <= ST_RUNNING;
                    end else begin
                        state_r <= ST_HALTED;
                    end
                end

                ST_RUNNING: begin
                    if (load_if.load_valid) begin
                        state_r      <= ST_LOADING;
                        load_ready_r <= 1'b1;
                    end else if (halt || !run) begin
                        state_r <= ST_HALTED;
                    end else if (tick_rise_s) begin
                        pc_r       <= adv_pc_s;
                        wrapped_r  <= wrapped_r | adv_wrap_s;
                        adv_pend_r <= 1'b1;
                        state_r    <= ST_RUNNING;
                    end else begin
                        state_r <= ST_RUNNING;
                    end
                end

                ST_STEP_ARMED: begin
                    // Extra step pulses while armed have no effect.
                    if (load_if.load_valid) begin
                        state_r      <= ST_LOADING;
                        load_ready_r <= 1'b1;
                    end else if (halt) begin
                        state_r <= ST_HALTED;
                    end else if (tick_rise_s) begin
                        pc_r       <= adv_pc_s;
                        wrapped_r  <= wrapped_r | adv_wrap_s;
                        adv_pend_r <= 1'b1;
                        state_r    <= ST_HALTED;
                    end else begin
                        state_r <= ST_STEP_ARMED;
                    end
                end

                default: begin
                    state_r <= ST_HALTED;
                end
            endcase
        end
    end

    assign pc_out             = pc_r;
    assign pc_adv             = pc_adv_r;
    assign state_out          = state_r;
    assign wrapped            = wrapped_r;
    assign load_if.load_ready = load_ready_r;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized run/step/halt/load/tick traffic, all compared every cycle
// against a behavioural model of the sequencer.  Build with +define+
// PC_BOUND_EN to exercise the bounded variant (END_ADDR = 16'h00FF).
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int          W     = 16;
    localparam logic [15:0] RST_A = 16'h0000;
`ifdef PC_BOUND_EN
    localparam logic [15:0] END_A = 16'h00FF;
    localparam bit          BOUND = 1'b1;
`else
    localparam logic [15:0] END_A = 16'hFFFF;
    localparam bit          BOUND = 1'b0;
`endif

    // Mode numbers as they appear on state_out.
    localparam int M_HALTED  = 0;
    localparam int M_RUNNING = 1;
    localparam int M_ARMED   = 2;
    localparam int M_LOADING = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_in = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] pc_out;
    logic        pc_adv;
    logic [1:0]  state_out;
    logic        wrapped;

    pc_sequencer_if #(.PC_WIDTH(W)) lif ();

    pc_sequencer #(
        .PC_WIDTH   (W),
        .RESET_ADDR (RST_A),
        .PC_INC     (1),
        .END_ADDR   (END_A)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (tick_in),
        .run       (run),
        .step      (step),
        .halt      (halt),
        .load_if   (lif.slave),
        .pc_out    (pc_out),
        .pc_adv    (pc_adv),
        .state_out (state_out),
        .wrapped   (wrapped)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int adv_seen = 0;

    // Behavioural model state.
    int          m_mode;
    int          m_pc;
    bit          m_wrapped;
    bit          m_tick_1;   // tick_in seen at the last edge
    bit          m_tick_2;   // tick_in seen at the edge before
    bit          m_chg_1;    // PC changed at the last edge
    bit          m_chg_2;    // PC changed at the edge before

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = M_HALTED;
        m_pc      = int'(RST_A);
        m_wrapped = 1'b0;
        m_tick_1  = 1'b0;
        m_tick_2  = 1'b0;
        m_chg_1   = 1'b0;
        m_chg_2   = 1'b0;
    endtask

    // One advance of the PC by the arithmetic rule.
    task automatic model_advance();
        int nxt;
        nxt = m_pc + 1;
        if (BOUND && (m_pc >= int'(END_A))) begin
            m_pc      = int'(RST_A);
            m_wrapped = 1'b1;
        end else if (nxt >= (1 << W)) begin
            m_pc      = nxt - (1 << W);
            m_wrapped = 1'b1;
        end else begin
            m_pc = nxt;
        end
    endtask

    // Model effect of one clk edge with the currently applied inputs.
    task automatic model_step();
        bit rise;
        bit chg;
        rise = m_tick_1 && !m_tick_2;   // a slow-clock rise becomes usable one edge later
        chg  = 1'b0;
        if (m_mode == M_LOADING) begin
            if (lif.load_valid) begin
                m_pc      = int'(lif.load_addr);
                m_wrapped = 1'b0;
                chg       = 1'b1;
            end
            m_mode = run ? M_RUNNING : M_HALTED;
        end else if (lif.load_valid) begin
            m_mode = M_LOADING;
        end else if (halt) begin
            m_mode = M_HALTED;
        end else if (m_mode == M_HALTED) begin
            if (step)     m_mode = M_ARMED;
            else if (run) m_mode = M_RUNNING;
        end else if (m_mode == M_RUNNING) begin
            if (!run) begin
                m_mode = M_HALTED;
            end else if (rise) begin
                model_advance();
                chg = 1'b1;
            end
        end else begin
            if (rise) begin
                model_advance();
                chg    = 1'b1;
                m_mode = M_HALTED;
            end
        end
        m_tick_2 = m_tick_1;
        m_tick_1 = tick_in;
        m_chg_2  = m_chg_1;
        m_chg_1  = chg;
    endtask

    // Compare all outputs mid-cycle, then advance one clock with the model.
    task automatic cycle();
        @(negedge clk);
        check_val("pc_out",     pc_out,         m_pc);
        check_val("state_out",  state_out,      m_mode);
        check_val("pc_adv",     pc_adv,         m_chg_2);
        check_val("wrapped",    wrapped,        m_wrapped);
        check_val("load_ready", lif.load_ready, (m_mode == M_LOADING));
        if (pc_adv) adv_seen++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check_val("rst_pc",      pc_out,         RST_A);
        check_val("rst_state",   state_out,      2'b00);
        check_val("rst_wrapped", wrapped,        1'b0);
        check_val("rst_pc_adv",  pc_adv,         1'b0);
        check_val("rst_ready",   lif.load_ready, 1'b0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic tick_pulse();
        tick_in = 1'b1;
        repeat (3) cycle();
        tick_in = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic do_load(input logic [15:0] addr);
        lif.load_valid = 1'b1;
        lif.load_addr  = addr;
        cycle();
        cycle();
        lif.load_valid = 1'b0;
    endtask

    initial begin
        int   tick_left;
        bit   hs;
        int   keep_pc;

        lif.load_valid = 1'b0;
        lif.load_addr  = 16'h0000;
        apply_reset();

        // Free run over three slow-clock edges.
        run = 1'b1;
        cycle();
        cycle();
        adv_seen = 0;
        repeat (3) tick_pulse();
        repeat (2) cycle();
        check_val("run3_pc",  pc_out,   16'h0003);
        check_val("run3_adv", adv_seen, 3);
        repeat (2) tick_pulse();
        check_val("run5_pc", pc_out, 16'h0005);

        // Asynchronous reset while running.
        run = 1'b0;
        apply_reset();

        // Single step: exactly one advance over two edges.
        step = 1'b1;
        cycle();
        step = 1'b0;
        cycle();
        check_val("armed_state", state_out, 2'b10);
        adv_seen = 0;
        repeat (2) tick_pulse();
        check_val("step_pc",    pc_out,    16'h0001);
        check_val("step_state", state_out, 2'b00);
        check_val("step_adv",   adv_seen,  1);

        // Load colliding with a slow-clock rise while running.
        run = 1'b1;
        cycle();
        cycle();
        tick_in = 1'b1;
        cycle();
        lif.load_valid = 1'b1;
        lif.load_addr  = 16'h00A0;
        adv_seen = 0;
        cycle();
        check_val("ld_ready_hi", lif.load_ready, 1'b1);
        cycle();
        lif.load_valid = 1'b0;
        check_val("ld_ready_lo", lif.load_ready, 1'b0);
        repeat (3) cycle();
        tick_in = 1'b0;
        repeat (2) cycle();
        check_val("ld_pc",  pc_out,   16'h00A0);
        check_val("ld_adv", adv_seen, 1);

        // Wrap at the top of the address space.
        do_load(16'hFFFF);
        tick_pulse();
        check_val("wrap_pc",      pc_out,  16'h0000);
        check_val("wrap_flag",    wrapped, 1'b1);

        // Wrap at the bound (only in the bounded build).
        do_load(16'h00FF);
        tick_pulse();
        check_val("bound_pc",   pc_out,  BOUND ? RST_A : 16'h0100);
        check_val("bound_flag", wrapped, BOUND ? 1'b1 : 1'b0);

        // Halt cancels an armed step.
        run = 1'b0;
        cycle();
        cycle();
        keep_pc = m_pc;
        step = 1'b1;
        cycle();
        step = 1'b0;
        cycle();
        check_val("arm2_state", state_out, 2'b10);
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        cycle();
        check_val("cancel_state", state_out, 2'b00);
        tick_pulse();
        check_val("cancel_pc",     pc_out,    keep_pc);
        check_val("cancel_state2", state_out, 2'b00);

        // Randomized traffic.
        tick_left = 2;
        for (int i = 0; i < 3000; i++) begin
            if (tick_left == 0) begin
                tick_in   = ~tick_in;
                tick_left = $urandom_range(0, 5);
            end else begin
                tick_left--;
            end
            if ($urandom_range(0, 19) == 0) run = ~run;
            step = ($urandom_range(0, 9) == 0);
            halt = ($urandom_range(0, 24) == 0);
            if (!lif.load_valid && ($urandom_range(0, 29) == 0)) begin
                lif.load_valid = 1'b1;
                case ($urandom_range(0, 3))
                    0:       lif.load_addr = 16'hFFFF;
                    1:       lif.load_addr = END_A;
                    2:       lif.load_addr = 16'(END_A - 16'h0001);
                    default: lif.load_addr = 16'($urandom);
                endcase
            end
            hs = lif.load_valid && (m_mode == M_LOADING);
            cycle();
            if (hs) lif.load_valid = 1'b0;
            if (i == 1500) apply_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_pc_sequencer
